// File: rtl/gauss_window_feeder.sv
// Gaussian tap feeder: per-line sliding window with edge handling and binomially weighted taps.
// Build option: define GAUSS_FEEDER_ZERO_PAD_EN for zero-padded line edges instead of replication.
module gauss_window_feeder #(
  parameter int KERNEL_SIZE  = 5,
  parameter int PIXEL_WIDTH  = 8,
  parameter int NUMBER_WIDTH = PIXEL_WIDTH + KERNEL_SIZE - 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     data_valid_i,
  input  logic                                     sop_i,
  input  logic                                     eop_i,
  input  logic [PIXEL_WIDTH-1:0]                   data_i,
  output logic                                     ready_o,
  output logic                                     data_valid_o,
  output logic                                     sop_o,
  output logic                                     eop_o,
  output logic [KERNEL_SIZE-1:0][NUMBER_WIDTH-1:0] data_o
);
  // state | meaning
  // IDLE  | waiting for sop, other beats dropped
  // FILL  | window not yet deep enough to center the first pixel
  // RUN   | every accepted beat emits one vector
  // FLUSH | R cycles feeding edge samples to drain the line tail

  localparam int R  = (KERNEL_SIZE - 1) / 2;
  localparam int CW = $clog2(R + 2);
  localparam logic [CW-1:0] R_C = CW'(R);

`ifdef GAUSS_FEEDER_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  function automatic int binom(input int n, input int k);
    int c;
    c = 1;
    for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
    return c;
  endfunction

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  state_t r_state, w_state_nxt;

  logic [PIXEL_WIDTH-1:0] r_win [KERNEL_SIZE];
  logic [CW-1:0]          r_pend;
  logic [CW-1:0]          r_flush_cnt;
  logic                   r_first;
  logic                   r_emit;
  logic                   r_emit_sop;
  logic                   r_emit_eop;

  logic                   w_accept;
  logic                   w_load;
  logic                   w_shift;
  logic                   w_emit;
  logic                   w_emit_eop;
  logic                   w_to_flush;
  logic [PIXEL_WIDTH-1:0] w_shift_in;
  logic [KERNEL_SIZE-1:0][NUMBER_WIDTH-1:0] w_taps;

  assign ready_o  = (r_state != FLUSH);
  assign w_accept = data_valid_i && ready_o;
  assign w_shift_in = (r_state == FLUSH) ? (ZERO_PAD ? '0 : r_win[KERNEL_SIZE-1]) : data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // r_pend counts samples since sop and saturates at R; a shift emits once it has reached R
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_emit      = 1'b0;
    w_emit_eop  = 1'b0;
    w_to_flush  = 1'b0;
    case (r_state)
      IDLE, FILL, RUN: begin
        if (w_accept && sop_i) begin
          w_load     = 1'b1;
          w_to_flush = eop_i;
          if (eop_i) w_state_nxt = FLUSH;
          else       w_state_nxt = FILL;
        end else if (w_accept && (r_state != IDLE)) begin
          w_shift    = 1'b1;
          w_emit     = (r_pend >= R_C);
          w_to_flush = eop_i;
          if (eop_i)       w_state_nxt = FLUSH;
          else if (w_emit) w_state_nxt = RUN;
        end
      end
      FLUSH: begin
        w_shift = 1'b1;
        w_emit  = (r_pend >= R_C);
        if (r_flush_cnt == CW'(1)) begin
          w_emit_eop  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < KERNEL_SIZE; k++) r_win[k] <= '0;
      r_pend      <= '0;
      r_flush_cnt <= '0;
      r_first     <= 1'b0;
      r_emit      <= 1'b0;
      r_emit_sop  <= 1'b0;
      r_emit_eop  <= 1'b0;
    end else begin
      r_emit     <= w_emit;
      r_emit_sop <= w_emit && r_first;
      r_emit_eop <= w_emit_eop;
      if (w_load) begin
        for (int k = 0; k < KERNEL_SIZE; k++)
          r_win[k] <= (ZERO_PAD && (k != KERNEL_SIZE - 1)) ? '0 : data_i;
        r_pend  <= CW'(1);
        r_first <= 1'b1;
      end else if (w_shift) begin
        for (int k = 0; k < KERNEL_SIZE - 1; k++) r_win[k] <= r_win[k+1];
        r_win[KERNEL_SIZE-1] <= w_shift_in;
        if (w_emit) r_first <= 1'b0;
        else        r_pend  <= r_pend + CW'(1);
      end
      if (w_to_flush)              r_flush_cnt <= R_C;
      else if (r_state == FLUSH)   r_flush_cnt <= r_flush_cnt - CW'(1);
    end
  end

  for (genvar k = 0; k < KERNEL_SIZE; k++) begin : g_tap
    localparam logic [NUMBER_WIDTH-1:0] COEF = NUMBER_WIDTH'(binom(KERNEL_SIZE - 1, k));
    assign w_taps[k] = NUMBER_WIDTH'(r_win[k]) * COEF;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_valid_o <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
      data_o       <= '0;
    end else begin
      data_valid_o <= r_emit;
      sop_o        <= r_emit_sop;
      eop_o        <= r_emit_eop;
      if (r_emit) data_o <= w_taps;
    end
  end

endmodule

// File: tb/tb_gauss_window_feeder.sv
// Bench for gauss_window_feeder: directed line cases plus randomized lines against a per-line model.
module tb_gauss_window_feeder;
  localparam int KS = 5;
  localparam int PW = 8;
  localparam int NW = PW + KS - 1;
  localparam int R  = (KS - 1) / 2;

`ifdef GAUSS_FEEDER_ZERO_PAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  typedef logic [KS-1:0][NW-1:0] vec_d_t;
  typedef struct {
    vec_d_t d;
    logic   s;
    logic   e;
    int     cyc;
  } vec_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          data_valid_i;
  logic          sop_i;
  logic          eop_i;
  logic [PW-1:0] data_i;
  logic          ready_o;
  logic          data_valid_o;
  logic          sop_o;
  logic          eop_o;
  vec_d_t        data_o;

  gauss_window_feeder #(.KERNEL_SIZE(KS), .PIXEL_WIDTH(PW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_valid_i (data_valid_i),
    .sop_i        (sop_i),
    .eop_i        (eop_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .data_valid_o (data_valid_o),
    .sop_o        (sop_o),
    .eop_o        (eop_o),
    .data_o       (data_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_pass = 0;
  int   n_checks = 0;
  int   cyc = 0;
  int   flush_left = 0;
  int   ready_low = 0;
  bit   in_line = 1'b0;
  int   line_px[$];
  vec_t exp_q[$];
  vec_t cap[$];
  int   coef[KS] = '{1, 4, 6, 4, 1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic vec_d_t v5(input int a0, input int a1, input int a2, input int a3, input int a4);
    vec_d_t v;
    v[0] = NW'(a0); v[1] = NW'(a1); v[2] = NW'(a2); v[3] = NW'(a3); v[4] = NW'(a4);
    return v;
  endfunction

  // Tap k of the vector centered on pixel c reads pixel c+k-R, with line-edge handling.
  function automatic vec_d_t mk(input int len, input int c);
    vec_d_t v;
    int idx, val;
    for (int k = 0; k < KS; k++) begin
      idx = c + k - R;
      if (idx < 0)          val = ZP ? 0 : line_px[0];
      else if (idx >= len)  val = ZP ? 0 : line_px[len-1];
      else                  val = line_px[idx];
      v[k] = NW'(val * coef[k]);
    end
    return v;
  endfunction

  task automatic push_exp(input int len, input int c, input bit fin);
    vec_t x;
    x.d = mk(len, c);
    x.s = (c == 0);
    x.e = fin && (c == len - 1);
    x.cyc = 0;
    exp_q.push_back(x);
  endtask

  task automatic finish_line();
    int len;
    len = line_px.size();
    for (int c = (len > R) ? len - R : 0; c < len; c++) push_exp(len, c, 1'b1);
    in_line = 1'b0;
  endtask

  task automatic model_beat(input bit s, input bit e, input int d, output bit ended);
    int n;
    ended = 1'b0;
    if (s) begin
      line_px.delete();
      line_px.push_back(d);
      in_line = 1'b1;
      if (e) begin finish_line(); ended = 1'b1; end
    end else if (in_line) begin
      line_px.push_back(d);
      n = line_px.size();
      if (n > R) push_exp(n, n - 1 - R, 1'b0);
      if (e) begin finish_line(); ended = 1'b1; end
    end
  endtask

  task automatic check_out();
    vec_t x, o;
    if (data_valid_o === 1'b1) begin
      o.d = data_o; o.s = sop_o; o.e = eop_o; o.cyc = cyc;
      cap.push_back(o);
      chk("vector_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("vec_data", 64'(data_o), 64'(x.d));
        chk("vec_sop", 64'(sop_o), 64'(x.s));
        chk("vec_eop", 64'(eop_o), 64'(x.e));
      end
    end else begin
      chk("idle_flags", 64'({sop_o, eop_o}), 64'(0));
    end
  endtask

  task automatic step(input bit v, input bit s, input bit e, input int d);
    bit acc, ended, exp_ready;
    data_valid_i = v; sop_i = s; eop_i = e; data_i = PW'(d);
    exp_ready = (flush_left == 0);
    chk("ready", 64'(ready_o), 64'(exp_ready));
    if (ready_o === 1'b0) ready_low++;
    acc = v && exp_ready;
    ended = 1'b0;
    if (acc) model_beat(s, e, d, ended);
    if (flush_left > 0) flush_left--;
    if (ended) flush_left = R;
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    check_out();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  vec_d_t e_first, e_last, e_single, e_79a, e_79b, e_50;
  int b_cyc, eop_cyc, n_eop, len;
  bit abort;

  initial begin
`ifdef GAUSS_FEEDER_ZERO_PAD_EN
    e_first  = v5(0, 0, 60, 80, 30);
    e_last   = v5(40, 200, 360, 0, 0);
    e_single = v5(0, 0, 600, 0, 0);
    e_79a    = v5(0, 0, 42, 36, 0);
    e_79b    = v5(0, 28, 54, 0, 0);
    e_50     = v5(0, 0, 300, 200, 50);
`else
    e_first  = v5(10, 40, 60, 80, 30);
    e_last   = v5(40, 200, 360, 240, 60);
    e_single = v5(100, 400, 600, 400, 100);
    e_79a    = v5(7, 28, 42, 36, 9);
    e_79b    = v5(7, 28, 54, 36, 9);
    e_50     = v5(50, 200, 300, 200, 50);
`endif
    data_valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; data_i = '0;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", 64'(ready_o), 64'(1));
    chk("rst_valid", 64'(data_valid_o), 64'(0));
    chk("rst_flags", 64'({sop_o, eop_o}), 64'(0));
    chk("rst_data", 64'(data_o), 64'(0));
    rst_i = 1'b0;
    idle(2);

    // line 10..60 back-to-back
    cap.delete(); ready_low = 0;
    step(1, 1, 0, 10); step(1, 0, 0, 20); step(1, 0, 0, 30);
    b_cyc = cyc;
    step(1, 0, 0, 40); step(1, 0, 0, 50); step(1, 0, 1, 60);
    idle(R + 3);
    chk("line6_count", 64'(cap.size()), 64'(6));
    chk("line6_ready_low", 64'(ready_low), 64'(R));
    if (cap.size() == 6) begin
      chk("line6_first", 64'(cap[0].d), 64'(e_first));
      chk("line6_first_sop", 64'(cap[0].s), 64'(1));
      chk("line6_first_latency", 64'(cap[0].cyc), 64'(b_cyc + 1));
      chk("line6_last", 64'(cap[5].d), 64'(e_last));
      chk("line6_last_eop", 64'(cap[5].e), 64'(1));
    end

    // single-pixel line
    cap.delete(); ready_low = 0;
    step(1, 1, 1, 100);
    idle(R + 2);
    chk("single_count", 64'(cap.size()), 64'(1));
    chk("single_ready_low", 64'(ready_low), 64'(R));
    if (cap.size() == 1) begin
      chk("single_data", 64'(cap[0].d), 64'(e_single));
      chk("single_flags", 64'({cap[0].s, cap[0].e}), 64'(3));
    end

    // two-pixel line, both vectors during flush
    cap.delete();
    step(1, 1, 0, 7); step(1, 0, 1, 9);
    eop_cyc = cyc;
    idle(R + 2);
    chk("two_count", 64'(cap.size()), 64'(2));
    if (cap.size() == 2) begin
      chk("two_v0", 64'(cap[0].d), 64'(e_79a));
      chk("two_v1", 64'(cap[1].d), 64'(e_79b));
      chk("two_v0_cyc", 64'(cap[0].cyc), 64'(eop_cyc + 2));
      chk("two_v1_cyc", 64'(cap[1].cyc), 64'(eop_cyc + 3));
    end

    // abort by new sop
    cap.delete();
    step(1, 1, 0, 1); step(1, 0, 0, 2); step(1, 0, 0, 3);
    step(1, 1, 0, 50); step(1, 0, 0, 50); step(1, 0, 0, 50); step(1, 0, 1, 50);
    idle(R + 2);
    n_eop = 0;
    foreach (cap[i]) if (cap[i].e) n_eop++;
    chk("abort_count", 64'(cap.size()), 64'(5));
    chk("abort_eop_count", 64'(n_eop), 64'(1));
    if (cap.size() == 5) begin
      chk("abort_new_first", 64'(cap[1].d), 64'(e_50));
      chk("abort_new_sop", 64'(cap[1].s), 64'(1));
    end

    // stray beats in IDLE
    cap.delete();
    step(1, 0, 0, 77); step(1, 0, 1, 88); step(0, 1, 1, 99);
    idle(3);
    chk("stray_count", 64'(cap.size()), 64'(0));

    // reset mid-RUN
    step(1, 1, 0, 11); step(1, 0, 0, 22); step(1, 0, 0, 33); step(1, 0, 0, 44);
    chk("pre_reset_valid", 64'(data_valid_o), 64'(1));
    rst_i = 1'b1; data_valid_i = 1'b0;
    #1;
    chk("midrst_valid", 64'(data_valid_o), 64'(0));
    chk("midrst_data", 64'(data_o), 64'(0));
    chk("midrst_ready", 64'(ready_o), 64'(1));
    exp_q.delete(); line_px.delete(); in_line = 1'b0; flush_left = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    cap.delete();
    idle(4);
    chk("post_reset_quiet", 64'(cap.size()), 64'(0));

    // randomized lines with gaps, junk during gaps/flush, strays and aborts
    for (int ln = 0; ln < 40; ln++) begin
      repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      len = $urandom_range(1, 12);
      abort = ($urandom_range(0, 5) == 0) && (len > 1);
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 2) == 0)
          step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
        step(1'b1, (i == 0), (i == len - 1) && !abort, int'($urandom_range(0, 255)));
      end
      if (!abort)
        repeat (R) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    end
    idle(R + 4);
    chk("exp_queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
